// File: rtl/inst_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD FSM that fetches one byte per request
// and holds it for the CPU. Jumps landing while a request is in flight are
// deferred until that request is acknowledged. The outstanding read is always
// completed, and its data is then thrown away.
// Ports: clk, rst (async, active-low), en, jmp, jmp_addr;
//        memory side mem_req/mem_addr/mem_ack/mem_data;
//        CPU side inst/inst_valid/inst_taken; pc = next fetch address.
module inst_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       jmp,
    input  logic [7:0] jmp_addr,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] inst,
    output logic       inst_valid,
    input  logic       inst_taken,
    output logic [7:0] pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] inst_q, inst_d;
    logic       jmp_pend_q, jmp_pend_d;
    logic [7:0] pend_addr_q, pend_addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= 8'h00;
            inst_q      <= 8'h00;
            jmp_pend_q  <= 1'b0;
            pend_addr_q <= 8'h00;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            jmp_pend_q  <= jmp_pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        jmp_pend_d  = jmp_pend_q;
        pend_addr_d = pend_addr_q;
        unique case (state_q)
            IDLE: begin
                if (jmp) begin
                    pc_d    = jmp_addr;
                    state_d = en ? REQ : IDLE;
                end else if (en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (jmp || jmp_pend_q) begin
                        // Redirected fetch: drop the returned byte and
                        // use the newest target.
                        pc_d       = jmp ? jmp_addr : pend_addr_q;
                        jmp_pend_d = 1'b0;
                        state_d    = en ? REQ : IDLE;
                    end else begin
                        inst_d  = mem_data;
                        pc_d    = pc_q + 8'd1;
                        state_d = HOLD;
                    end
                end else if (jmp) begin
                    // The address must stay stable until ack, so the
                    // jump is parked until then.
                    jmp_pend_d  = 1'b1;
                    pend_addr_d = jmp_addr;
                end
            end
            HOLD: begin
                if (jmp) begin
                    pc_d    = jmp_addr;
                    state_d = en ? REQ : IDLE;
                end else if (inst_taken) begin
                    state_d = en ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req    = (state_q == REQ);
        inst_valid = (state_q == HOLD);
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign inst     = inst_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port en, input, 1 bit: run enable; 1 permits new fetches.
REQ-004 The block SHALL have port jmp, input, 1 bit: load the program counter from jmp_addr.
REQ-005 The block SHALL have port jmp_addr, input, 8 bits: jump target address.
REQ-006 The block SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-007 The block SHALL have port mem_addr, output, 8 bits: read address; always equals pc.
REQ-008 The block SHALL have port mem_ack, input, 1 bit: memory read data valid for the current request.
REQ-009 The block SHALL have port mem_data, input, 8 bits: instruction byte, sampled only when mem_req=1 and mem_ack=1.
REQ-010 The block SHALL have port inst, output, 8 bits: registered instruction presented to the CPU.
REQ-011 The block SHALL have port inst_valid, output, 1 bit: inst holds an unconsumed instruction.
REQ-012 The block SHALL have port inst_taken, input, 1 bit: CPU consumes inst this cycle; ignored while inst_valid=0.
REQ-013 The block SHALL have port pc, output, 8 bits: address of the next byte to fetch.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, REQ and HOLD.
REQ-015 In IDLE, mem_req=0 and inst_valid=0; when en=1, the FSM SHALL go to REQ on the next edge.
REQ-016 In REQ, mem_req SHALL be 1 and mem_addr=pc, both held stable until mem_ack=1; a request is never withdrawn.
REQ-017 In REQ with mem_ack=1 and no jump pending, the block SHALL load inst <= mem_data, set pc <= pc+1 and go to HOLD.
REQ-018 pc arithmetic SHALL be modulo 256: 8'hFF+1 = 8'h00, with no flag.
REQ-019 In HOLD, inst_valid SHALL be 1 and inst stable; on inst_taken=1 the FSM SHALL go to REQ if en=1, else to IDLE.
REQ-020 Throughput with a zero-wait memory (mem_ack=1 in the first REQ cycle) and inst_taken held 1 SHALL be one instruction per 2 cycles.
REQ-021 Deasserting en in REQ SHALL NOT abort the handshake; the fetch completes and the FSM goes to HOLD.
REQ-022 jmp=1 in IDLE or HOLD SHALL set pc <= jmp_addr and inst_valid <= 0, then go to REQ if en=1, else to IDLE; the instruction held in HOLD is discarded.
REQ-023 jmp=1 in REQ without mem_ack SHALL set jmp_pend <= 1 and latch jmp_addr into pend_addr; mem_addr stays the old pc until ack.
REQ-024 On mem_ack in REQ with jmp_pend=1 or jmp=1, the block SHALL discard mem_data, set pc <= the latest jump target (jmp_addr when jmp=1, else pend_addr), clear jmp_pend, and re-enter REQ (en=1) or go to IDLE (en=0).
REQ-025 A jmp in HOLD in the same cycle as inst_taken SHALL take priority; the instruction counts as consumed and the jump proceeds as in REQ-022.
REQ-026 mem_ack outside REQ SHALL be ignored.

Reset
REQ-027 While rst=0, asynchronously: FSM=IDLE, pc=8'h00, inst=8'h00, inst_valid=0, mem_req=0, jmp_pend=0, pend_addr=8'h00.
REQ-028 Reset asserted mid-handshake SHALL drop mem_req immediately; a mem_ack arriving afterwards is ignored.
REQ-029 After rst rises, the first fetch SHALL be from address 8'h00 once en=1.

Verification
REQ-030 Fetch: rst released, en=1, memory returns 8'hAA, 8'hBB at addresses 0 and 1 with 2-cycle ack latency, inst_taken=1 -> inst=8'hAA then 8'hBB, pc=8'h02, mem_req stable during waits.
REQ-031 Backpressure: inst_taken=0 for 5 cycles in HOLD -> inst_valid=1 and inst unchanged, mem_req=0, pc unchanged.
REQ-032 Wrap: jmp to 8'hFF, fetch one byte -> mem_addr=8'hFF, then pc=8'h00.
REQ-033 Jump during wait: jmp_addr=8'h40 pulsed in REQ at addr 8'h05, ack 3 cycles later with 8'h11 -> 8'h11 never appears with inst_valid=1, next mem_addr=8'h40.
REQ-034 Jump and taken together in HOLD, jmp_addr=8'h20 -> inst_valid=0 next cycle, next request to 8'h20.
REQ-035 Reset mid-REQ: rst=0 while mem_req=1 -> mem_req=0, pc=8'h00 without a clock edge; a later stray mem_ack is ignored.
